// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the accumulator-ALU control stage.
//   data_src_t   : operand source select driven to the ALU
//   seq_state_t  : sequencer FSM states
//   COND_*       : branch condition codes (instruction bits [W+7:W+5])
//   *_OFS        : instruction field offsets, relative to bit WIDTH
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    DS_MEM = 2'b00,
    DS_IMM = 2'b01,
    DS_REG = 2'b11
  } data_src_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    OPER,
    EXEC,
    BRANCH,
    HALT
  } seq_state_t;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_CY     = 3'b011;
  localparam logic [2:0] COND_NCY    = 3'b100;
  localparam logic [2:0] COND_S      = 3'b101;
  localparam logic [2:0] COND_O      = 3'b110;
  localparam logic [2:0] COND_HALT   = 3'b111;

  // Field positions above the immediate; the absolute bit is WIDTH + offset.
  localparam int OP_OFS    = 5;
  localparam int SRC_OFS   = 3;
  localparam int CE_A_OFS  = 2;
  localparam int CE_CY_OFS = 1;
  localparam int KIND_OFS  = 0;

  // Raw src field to ALU select; 2'b10 is an alias of the memory source.
  function automatic data_src_t src_to_ds(input logic [1:0] src);
    data_src_t ds;
    unique case (src)
      2'b01:   ds = DS_IMM;
      2'b11:   ds = DS_REG;
      default: ds = DS_MEM;
    endcase
    return ds;
  endfunction

endpackage

// File: rtl/alu_seq_cond.sv
// Combinational branch-condition evaluator.
//   cond    : condition code from the instruction word
//   flag_*  : registered ALU flags
//   taken   : branch goes to the target
//   halt    : condition code requests HALT (taken is 0 then)
module alu_seq_cond
  import alu_sequencer_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       flag_cy,
  input  logic       flag_z,
  input  logic       flag_s,
  input  logic       flag_o,
  output logic       taken,
  output logic       halt
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    taken = 1'b0;
    halt  = 1'b0;
    unique case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = flag_z;
      COND_NZ:     taken = ~flag_z;
      COND_CY:     taken = flag_cy;
      COND_NCY:    taken = ~flag_cy;
      COND_S:      taken = flag_s;
      COND_O:      taken = flag_o;
      COND_HALT:   halt  = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Control stage in front of the accumulator ALU: fetches instruction words
// over a req/valid handshake, issues memory-operand reads, drives the ALU
// control inputs and evaluates conditional branches on the ALU flags.
//   start                  : level; leaves IDLE/HALT, fetch resumes at pc 0
//   instr_req/addr/valid/data : program-memory fetch handshake
//   mem_rd, mem_addr       : one-cycle data-memory read strobe and address
//   reg_sel                : register-file select
//   data_src, immediate, op, ce_a, ce_cy : ALU controls
//   flag_cy/z/s/o          : registered ALU flags
//   pc, busy, halted       : status
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PC_W      = 8,
  parameter int REG_SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 instr_req,
  output logic [PC_W-1:0]      instr_addr,
  input  logic                 instr_valid,
  input  logic [WIDTH+7:0]     instr_data,
  output logic                 mem_rd,
  output logic [WIDTH-1:0]     mem_addr,
  output logic [REG_SEL_W-1:0] reg_sel,
  output data_src_t            data_src,
  output logic [WIDTH-1:0]     immediate,
  output logic [2:0]           op,
  output logic                 ce_a,
  output logic                 ce_cy,
  input  logic                 flag_cy,
  input  logic                 flag_z,
  input  logic                 flag_s,
  input  logic                 flag_o,
  output logic [PC_W-1:0]      pc,
  output logic                 busy,
  output logic                 halted
);

  localparam int IR_W = WIDTH + 8;
  // Reset IR decodes as an immediate-source op 0 with zero immediate.
  localparam logic [IR_W-1:0] IR_RST = {3'b000, DS_IMM, 3'b000, {WIDTH{1'b0}}};

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q;
  logic            ir_load;
  logic            br_taken, br_halt;

  // Decode of the incoming word, used only to choose the post-fetch state.
  logic       new_kind;
  logic [1:0] new_src;
  assign new_kind = instr_data[WIDTH+KIND_OFS];
  assign new_src  = instr_data[WIDTH+SRC_OFS +: 2];

  alu_seq_cond u_cond (
    .cond    (ir_q[WIDTH+OP_OFS +: 3]),
    .flag_cy (flag_cy),
    .flag_z  (flag_z),
    .flag_s  (flag_s),
    .flag_o  (flag_o),
    .taken   (br_taken),
    .halt    (br_halt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= IR_RST;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      if (ir_load) ir_q <= instr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_load = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        if (instr_valid) begin
          ir_load = 1'b1;
          if (new_kind)               state_d = BRANCH;
          else if (src_to_ds(new_src) == DS_MEM) state_d = OPER;
          else                        state_d = EXEC;
        end
      end
      OPER: state_d = EXEC;
      EXEC: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = FETCH;
      end
      BRANCH: begin
        if (br_halt) begin
          state_d = HALT;
        end else begin
          pc_d    = br_taken ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the state register alone, so an asynchronous
  // reset drops them in the same instant it forces IDLE.
  assign instr_req  = (state_q == FETCH);
  assign mem_rd     = (state_q == OPER);
  assign ce_a       = (state_q == EXEC) && ir_q[WIDTH+CE_A_OFS];
  assign ce_cy      = (state_q == EXEC) && ir_q[WIDTH+CE_CY_OFS];
  assign busy       = (state_q != IDLE) && (state_q != HALT);
  assign halted     = (state_q == HALT);
  assign instr_addr = pc_q;
  assign pc         = pc_q;

  // ALU controls come straight from IR, which only changes on a fetch.
  assign data_src   = src_to_ds(ir_q[WIDTH+SRC_OFS +: 2]);
  assign op         = ir_q[WIDTH+OP_OFS +: 3];
  assign immediate  = ir_q[WIDTH-1:0];
  assign mem_addr   = ir_q[WIDTH-1:0];
  assign reg_sel    = ir_q[REG_SEL_W-1:0];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = '0;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [2:0]  reg_sel;
  data_src_t   data_src;
  logic [7:0]  immediate;
  logic [2:0]  op;
  logic        ce_a, ce_cy;
  logic        flag_cy = 1'b0, flag_z = 1'b0, flag_s = 1'b0, flag_o = 1'b0;
  logic [7:0]  pc;
  logic        busy, halted;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(8), .PC_W(8), .REG_SEL_W(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .reg_sel(reg_sel),
    .data_src(data_src), .immediate(immediate), .op(op),
    .ce_a(ce_a), .ce_cy(ce_cy),
    .flag_cy(flag_cy), .flag_z(flag_z), .flag_s(flag_s), .flag_o(flag_o),
    .pc(pc), .busy(busy), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] alu_word(input logic [2:0] o, input logic [1:0] src,
                                           input logic a, input logic cy, input logic [7:0] imm);
    return {o, src, a, cy, 1'b0, imm};
  endfunction

  function automatic logic [15:0] br_word(input logic [2:0] cond, input logic [7:0] tgt);
    return {cond, 2'b00, 1'b0, 1'b0, 1'b1, tgt};
  endfunction

  // Answer the pending fetch after dly wait cycles; returns on the falling
  // edge right after the word was captured.
  task automatic serve(input logic [15:0] word, input int dly);
    int n = 0;
    while (!instr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req_seen", instr_req, 1'b1);
    repeat (dly) begin
      check("ce_a_while_fetch", ce_a, 1'b0);
      @(negedge clk);
    end
    instr_valid = 1'b1;
    instr_data  = word;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1. reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_ce_a", ce_a, 1'b0);
      check("rst_ce_cy", ce_cy, 1'b0);
      check("rst_instr_req", instr_req, 1'b0);
      check("rst_mem_rd", mem_rd, 1'b0);
    end
    check("rst_pc", pc, 8'h00);
    check("rst_data_src", data_src, 2'b01);
    check("rst_immediate", immediate, 8'h00);
    check("rst_op", op, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("start_req", instr_req, 1'b1);
    check("start_addr", instr_addr, 8'h00);
    check("start_busy", busy, 1'b1);

    // 2. immediate op after a 3-cycle fetch delay; start stays high
    serve(alu_word(3'b001, 2'b01, 1'b1, 1'b0, 8'h5A), 3);
    check("imm_ce_a", ce_a, 1'b1);
    check("imm_ce_cy", ce_cy, 1'b0);
    check("imm_data_src", data_src, 2'b01);
    check("imm_immediate", immediate, 8'h5A);
    check("imm_op", op, 3'b001);
    check("imm_mem_rd", mem_rd, 1'b0);
    @(negedge clk);
    check("imm_ce_a_done", ce_a, 1'b0);
    check("imm_pc", pc, 8'h01);
    check("imm_next_addr", instr_addr, 8'h01);
    check("imm_next_req", instr_req, 1'b1);
    start = 1'b0;

    // 3. memory operand: mem_rd then ce
    serve(alu_word(3'b010, 2'b00, 1'b1, 1'b1, 8'h20), 1);
    check("mem_rd_pulse", mem_rd, 1'b1);
    check("mem_addr", mem_addr, 8'h20);
    check("mem_ce_a_early", ce_a, 1'b0);
    @(negedge clk);
    check("mem_rd_done", mem_rd, 1'b0);
    check("mem_ce_a", ce_a, 1'b1);
    check("mem_ce_cy", ce_cy, 1'b1);
    check("mem_data_src", data_src, 2'b00);
    check("mem_op", op, 3'b010);
    @(negedge clk);
    check("mem_pc", pc, 8'h02);

    // 4. branch on z, taken then not taken
    flag_z = 1'b1;
    serve(br_word(COND_Z, 8'h10), 0);
    check("brz_ce_a", ce_a, 1'b0);
    check("brz_ce_cy", ce_cy, 1'b0);
    check("brz_busy", busy, 1'b1);
    @(negedge clk);
    check("brz_taken_addr", instr_addr, 8'h10);
    check("brz_taken_ce_a", ce_a, 1'b0);
    flag_z = 1'b0;
    serve(br_word(COND_Z, 8'h40), 2);
    check("brz_nt_ce_a", ce_a, 1'b0);
    @(negedge clk);
    check("brz_nt_addr", instr_addr, 8'h11);

    // 5. jump to 0xFF, execute a register op there, pc wraps to 0
    serve(br_word(COND_ALWAYS, 8'hFF), 1);
    @(negedge clk);
    check("jmp_addr", instr_addr, 8'hFF);
    serve(alu_word(3'b011, 2'b11, 1'b1, 1'b0, 8'h05), 0);
    check("reg_data_src", data_src, 2'b11);
    check("reg_sel", reg_sel, 3'd5);
    check("reg_op", op, 3'b011);
    check("reg_ce_a", ce_a, 1'b1);
    @(negedge clk);
    check("wrap_addr", instr_addr, 8'h00);

    // 6a. halt at pc 1, then restart
    serve(alu_word(3'b000, 2'b01, 1'b0, 1'b1, 8'h00), 0);
    check("cy_only_ce_a", ce_a, 1'b0);
    check("cy_only_ce_cy", ce_cy, 1'b1);
    @(negedge clk);
    serve(br_word(COND_HALT, 8'h33), 0);
    check("halt_br_busy", busy, 1'b1);
    @(negedge clk);
    check("halt_halted", halted, 1'b1);
    check("halt_busy", busy, 1'b0);
    check("halt_pc", pc, 8'h01);
    check("halt_req", instr_req, 1'b0);
    repeat (2) @(negedge clk);
    check("halt_pc_frozen", pc, 8'h01);
    check("halt_still", halted, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_req", instr_req, 1'b1);
    check("restart_addr", instr_addr, 8'h00);
    check("restart_halted", halted, 1'b0);

    // 6b. reset during OPER aborts without a ce pulse
    serve(alu_word(3'b001, 2'b00, 1'b1, 1'b1, 8'h44), 2);
    check("abort_in_oper", mem_rd, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_ce_a", ce_a, 1'b0);
    check("abort_mem_rd", mem_rd, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_pc", pc, 8'h00);
    @(negedge clk);
    check("abort_ce_a_later", ce_a, 1'b0);
    check("abort_ce_cy_later", ce_cy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", busy, 1'b0);
    check("abort_idle_ce", ce_a, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control stage directly upstream of the accumulator ALU.
- Fetches instruction words from program memory over a valid/ready-style handshake, decodes them and drives the ALU control inputs: data_src, immediate, op, ce_a and ce_cy.
- Fetches memory operands and supplies the register-file select.
- Evaluates conditional branches on the registered ALU flags (flag_cy, flag_z, flag_s, flag_o).

Parameters:
- WIDTH, 8, datapath width; matches the ALU WIDTH.
- PC_W, 8, program counter width.
- REG_SEL_W, 3, register-file select width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low (rst==0 resets)
- start  input  1  level; leaves IDLE/HALT and begins fetching at PC 0
- instr_req  output  1  fetch request; held until instr_valid
- instr_addr  output  PC_W  fetch address (= pc)
- instr_valid  input  1  instr_data valid; any latency of 1 cycle or more
- instr_data  input  WIDTH+8  instruction word
- mem_rd  output  1  one-cycle data-memory read strobe
- mem_addr  output  WIDTH  data-memory address (= immediate field)
- reg_sel  output  REG_SEL_W  register select (= immediate[REG_SEL_W-1:0])
- data_src  output  2  data_src_t to ALU
- immediate  output  WIDTH  immediate to ALU
- op  output  3  ALU operation
- ce_a  output  1  accumulator/flags enable
- ce_cy  output  1  carry enable
- flag_cy, flag_z, flag_s, flag_o  input  1 each  registered ALU flags
- pc  output  PC_W  current program counter
- busy  output  1  high in any state except IDLE and HALT
- halted  output  1  high in HALT

Behaviour:
- Instruction fields:
  - [W+7:W+5] op or branch condition
  - [W+4:W+3] src
  - [W+2] ce_a
  - [W+1] ce_cy
  - [W] kind (0 = ALU, 1 = branch)
  - [W-1:0] imm, or branch target (low PC_W bits)
- data_src_t encoding: DS_MEM=2'b00 (2'b10 also means mem), DS_IMM=2'b01, DS_REG=2'b11.
- Reset values: state=IDLE, pc=0, all strobes (instr_req, mem_rd, ce_a, ce_cy) 0, data_src=DS_IMM, immediate=0, op=0, busy=0, halted=0.
- Reset mid-operation aborts immediately; no ce pulse leaks out.
- FSM states and transitions:
  - IDLE: start -> FETCH, with pc=0.
  - FETCH: instr_req=1 and instr_addr=pc. On instr_valid, latch instr_data into the instruction register (IR), then:
    - ALU kind with mem src -> OPER.
    - ALU kind with other src -> EXEC.
    - Branch kind -> BRANCH.
    - instr_valid is ignored outside FETCH.
  - OPER: mem_rd=1 for exactly this cycle, mem_addr=imm -> EXEC. Data is available the following cycle.
  - EXEC: exactly one cycle.
    - data_src, immediate, op and reg_sel are driven from IR.
    - ce_a and ce_cy equal their IR bits.
    - pc <= pc+1, wrapping modulo 2^PC_W -> FETCH.
  - BRANCH: one cycle; evaluates the condition against the current flags.
    - Conditions: 000 always, 001 z, 010 !z, 011 cy, 100 !cy, 101 s, 110 o, 111 halt.
    - Taken: pc <= target. Not taken: pc <= pc+1. Both -> FETCH.
    - Condition 111: pc unchanged -> HALT.
  - HALT: halted=1. start -> FETCH with pc=0.
- Timing:
  - The flags updated by an EXEC edge are visible to any later BRANCH, so a compare followed by a branch needs no stall.
  - ALU instruction latency, from instr_valid to the ce pulse: 1 cycle (reg/imm) or 2 cycles (mem).
- ALU control outputs (data_src, immediate, op, reg_sel, mem_addr) are registered from IR and stay stable outside EXEC.
- ce_a and ce_cy are 0 in every state except EXEC.
- A branch never pulses ce_a or ce_cy.
- start held high during a run has no effect.

Decomposition:
- Shared package (extend enums.svh):
  - data_src_t and its constants.
  - seq_state_t {IDLE, FETCH, OPER, EXEC, BRANCH, HALT}.
  - Branch-condition constants.
  - Instruction field offset localparams.
- One natural sub-module: alu_seq_cond, the combinational flag/condition evaluator.
- The FSM stays in alu_sequencer.

Test Plan:
1. Reset with rst=0 held for 3 cycles, then start=1 -> instr_req=1 and instr_addr=0; ce_a=0, ce_cy=0 throughout reset.
2. Immediate ALU op: word with op=3'b001, src=01, ce_a=1, imm=8'h5A, instr_valid after a 3-cycle delay -> exactly one EXEC cycle with data_src=01, immediate=8'h5A, op=001, ce_a=1; pc then reads 1.
3. Memory operand: src=00, imm=8'h20 -> mem_rd pulses one cycle with mem_addr=8'h20, ce_a pulses the next cycle, total 2 cycles after instr_valid.
4. Branch on flag_z: cond 001, target=8'h10, flag_z=1 -> next fetch address 0x10. With flag_z=0 -> next fetch address pc+1. Neither case pulses ce_a.
5. PC wrap: ALU instruction executed at pc=8'hFF -> next instr_addr=8'h00.
6. Halt: cond 111 -> halted=1, busy=0, pc frozen. Then start=1 -> fetch from 0. Separately, rst asserted during OPER -> IDLE and no ce pulse.
